// File: rtl/mdu_if.sv
// E-stage multiply/divide bus between the pipeline and the MDU sequencer.
// The pipeline drives the op, operands and flush. The MDU drives the stall and HI/LO outputs.
interface mdu_if;
  logic [3:0]  MDUop;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output MDUop, rs_data, rt_data, req,
    input  start, busy, hi, lo, md_out
  );

  modport slave (
    input  MDUop, rs_data, rt_data, req,
    output start, busy, hi, lo, md_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO for the E stage.
// The result is computed at issue time and committed after a modelled latency.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [31:0] hi_q, lo_q, hi_n, lo_n;
  logic        div_zero;
  logic        start, commit, wr_hi, wr_lo;

  logic [31:0]        rs, rt;
  logic               rt_zero, div_ovf;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] divisor_s;
  logic [31:0]        divisor_u;
  logic [31:0]        res_hi, res_lo;

  assign rs = bus.rs_data;
  assign rt = bus.rt_data;

  assign rt_zero = (rt == 32'd0);
  // Divisor 1 for the INT_MIN / -1 case yields the wrapped MIPS result directly.
  assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  assign prod_s    = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u    = {32'd0, rs} * {32'd0, rt};
  assign divisor_s = (rt_zero || div_ovf) ? 32'sd1 : $signed(rt);
  assign divisor_u = rt_zero ? 32'd1 : rt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (bus.MDUop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = $signed(rs) / divisor_s;
        res_hi = $signed(rs) % divisor_s;
      end
      OP_DIVU: begin
        res_lo = rs / divisor_u;
        res_hi = rs % divisor_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    start   = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.req) begin
          case (bus.MDUop)
            OP_MULT, OP_MULTU: begin
              start   = 1'b1;
              state_d = MULT;
              cnt_d   = MULT_N;
            end
            OP_DIV, OP_DIVU: begin
              start   = 1'b1;
              state_d = DIV;
              cnt_d   = DIV_N;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        // Ops arriving while busy are dropped; the hazard unit should never send them.
        if (cnt <= 6'd1) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt - 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: HI/LO and the shadows are reset too, so software never reads stale values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_n     <= '0;
      lo_n     <= '0;
      div_zero <= 1'b0;
    end else begin
      if (start) begin
        hi_n     <= res_hi;
        lo_n     <= res_lo;
        div_zero <= (bus.MDUop == OP_DIV || bus.MDUop == OP_DIVU) && rt_zero;
      end
      if (commit && !div_zero) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end
      if (wr_hi) hi_q <= rs;
      if (wr_lo) lo_q <= rs;
    end
  end

  assign bus.start  = start;
  assign bus.busy   = (state != IDLE);
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = (bus.MDUop == OP_MFHI) ? hi_q :
                      (bus.MDUop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of HI/LO and the busy latency.
module tb_mdu_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural HI/LO, pending result and remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_p_hi, m_p_lo;
  logic        m_p_ok;
  int          m_left;

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_p_hi = 0; m_p_lo = 0; m_p_ok = 0; m_left = 0;
  endtask

  function automatic logic exp_start();
    return (m_left == 0) && !bus.req && (bus.MDUop >= 4'd1) && (bus.MDUop <= 4'd4);
  endfunction

  function automatic logic [31:0] exp_md();
    if (bus.MDUop == 4'd5) return m_hi;
    if (bus.MDUop == 4'd6) return m_lo;
    return 32'd0;
  endfunction

  task automatic model_edge();
    logic [63:0] p;
    longint      q, r;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_p_ok) begin
        m_hi = m_p_hi;
        m_lo = m_p_lo;
      end
    end else if (!bus.req) begin
      case (bus.MDUop)
        4'd1: begin
          p = 64'(longint'($signed(bus.rs_data)) * longint'($signed(bus.rt_data)));
          m_p_hi = p[63:32]; m_p_lo = p[31:0]; m_p_ok = 1; m_left = MULT_N;
        end
        4'd2: begin
          p = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
          m_p_hi = p[63:32]; m_p_lo = p[31:0]; m_p_ok = 1; m_left = MULT_N;
        end
        4'd3: begin
          m_p_ok = (bus.rt_data != 0);
          if (m_p_ok) begin
            q = longint'($signed(bus.rs_data)) / longint'($signed(bus.rt_data));
            r = longint'($signed(bus.rs_data)) % longint'($signed(bus.rt_data));
            m_p_lo = q[31:0]; m_p_hi = r[31:0];
          end
          m_left = DIV_N;
        end
        4'd4: begin
          m_p_ok = (bus.rt_data != 0);
          if (m_p_ok) begin
            m_p_lo = bus.rs_data / bus.rt_data;
            m_p_hi = bus.rs_data % bus.rt_data;
          end
          m_left = DIV_N;
        end
        4'd7: m_hi = bus.rs_data;
        4'd8: m_lo = bus.rs_data;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rq);
    bus.MDUop = op; bus.rs_data = rs; bus.rt_data = rt; bus.req = rq;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    reset = 1'b0;
    drive(4'd1, 32'd1, 32'd1, 1'b0);
    n_checks++;
    if (bus.start !== 1'b1) begin
      n_fail++; $display("FAIL reset_start_comb start=%b expected 1", bus.start);
    end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (bus.start !== 1'b0 || bus.md_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_idle start=%b md_out=%h expected 0/0", bus.start, bus.md_out);
    end
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int n);
    drive(op, rs, rt, 1'b0);
    n_checks++;
    if (bus.start !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_issue start=%b busy=%b expected 1/0", name, bus.start, bus.busy);
    end
    tick();
    for (int i = 1; i <= n; i++) begin
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.start !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy cycle %0d busy=%b start=%b expected 1/0", name, i, bus.busy, bus.start);
      end
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s_result busy=%b hi=%h lo=%h expected 0 hi=%h lo=%h",
               name, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mul_div();
    run_md("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
    run_md("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULT_N);
    run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    run_md("divu",  4'd4, 32'd7,         32'd2, 32'd1,         32'd3,         DIV_N);
  endtask

  task automatic test_div_zero();
    drive(4'd7, 32'h1234, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (bus.hi !== 32'h1234) begin
      n_fail++; $display("FAIL mthi hi=%h expected 00001234", bus.hi);
    end
    drive(4'd8, 32'h5678, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (bus.lo !== 32'h5678 || bus.hi !== 32'h1234) begin
      n_fail++; $display("FAIL mtlo hi=%h lo=%h expected 00001234/00005678", bus.hi, bus.lo);
    end
    run_md("divu_by_zero", 4'd4, 32'd5, 32'd0, 32'h1234, 32'h5678, DIV_N);
  endtask

  task automatic test_req();
    drive(4'd1, 32'd9, 32'd9, 1'b1);
    n_checks++;
    if (bus.start !== 1'b0) begin
      n_fail++; $display("FAIL req_start start=%b expected 0", bus.start);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
      n_fail++;
      $display("FAIL req_suppress busy=%b hi=%h lo=%h expected 0/00001234/00005678", bus.busy, bus.hi, bus.lo);
    end
    drive(4'd1, 32'd100, 32'd200, 1'b0);
    tick();
    for (int c = 1; c <= MULT_N; c++) begin
      if (c == 2) drive(4'd1, 32'd3, 32'd3, 1'b1);
      else drive(4'd0, 32'd0, 32'd0, 1'b0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL req_inflight cycle %0d busy=%b expected 1", c, bus.busy);
      end
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd20000) begin
      n_fail++;
      $display("FAIL req_inflight_commit busy=%b hi=%h lo=%h expected 0/0/00004e20", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    #1 reset = 1'b0;
    run_md("mult_after_reset", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, MULT_N);
  endtask

  task automatic test_md_read();
    logic [31:0] old_lo;
    old_lo = m_lo;
    drive(4'd1, 32'd16, 32'd16, 1'b0);
    tick();
    for (int i = 1; i <= MULT_N; i++) begin
      drive(4'd6, 32'd0, 32'd0, 1'b0);
      n_checks++;
      if (bus.md_out !== old_lo || bus.start !== 1'b0) begin
        n_fail++;
        $display("FAIL mflo_busy cycle %0d md_out=%h start=%b expected %h/0", i, bus.md_out, bus.start, old_lo);
      end
      tick();
    end
    drive(4'd6, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (bus.md_out !== 32'd256) begin
      n_fail++; $display("FAIL mflo_after md_out=%h expected 00000100", bus.md_out);
    end
    drive(4'd5, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (bus.md_out !== 32'd0) begin
      n_fail++; $display("FAIL mfhi md_out=%h expected 0", bus.md_out);
    end
    drive(4'd9, 32'hDEAD_BEEF, 32'd1, 1'b0);
    n_checks++;
    if (bus.md_out !== 32'd0 || bus.start !== 1'b0) begin
      n_fail++; $display("FAIL op9_comb md_out=%h start=%b expected 0/0", bus.md_out, bus.start);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd256) begin
      n_fail++;
      $display("FAIL op9_state busy=%b hi=%h lo=%h expected 0/0/00000100", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd1, 32'd3, 32'd4, 1'b0);
    tick();
    for (int i = 1; i <= MULT_N; i++) begin
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      tick();
    end
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    n_checks++;
    if (bus.start !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== 32'd12) begin
      n_fail++;
      $display("FAIL b2b_issue start=%b busy=%b lo=%h expected 1/0/0000000c", bus.start, bus.busy, bus.lo);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy busy=%b expected 1", bus.busy);
    end
    for (int i = 1; i <= DIV_N; i++) begin
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_result busy=%b hi=%h lo=%h expected 0/2/0000000e", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        rq;
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rq = ($urandom_range(0, 5) == 0);
      drive(op, rs, rt, rq);
      n_checks++;
      if (bus.start !== exp_start() || bus.busy !== (m_left > 0) || bus.md_out !== exp_md() ||
          bus.hi !== m_hi || bus.lo !== m_lo || (bus.start && bus.busy)) begin
        n_fail++;
        $display("FAIL random cycle %0d op=%0d start=%b busy=%b md_out=%h hi=%h lo=%h expected %b/%b/%h/%h/%h",
                 i, op, bus.start, bus.busy, bus.md_out, bus.hi, bus.lo,
                 exp_start(), (m_left > 0), exp_md(), m_hi, m_lo);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mul_div();
    test_div_zero();
    test_req();
    test_reset_mid();
    test_md_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
